// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch/jump flushes with PC redirect, memory-busy freeze.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned XREG_ADDRWIDTH = 5,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs1_rd,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs2_rd,
  input  logic [6:0]                ex_opcode,
  input  logic                      ex_rd_en,
  input  logic [XREG_ADDRWIDTH-1:0] ex_rd_addr,
  input  logic                      ex_redirect,
  input  logic [31:0]               ex_redirect_pc,
  input  logic                      mem_busy,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      load_hazerd,
  output logic                      flush_flag,
  output logic                      pipe_freeze,
  output logic                      pc_redirect_valid,
  output logic [31:0]               pc_redirect_addr,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] LSTALL = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] FREEZE = 2'd3;

  localparam int unsigned MAXC = (LOAD_USE_STALL > FLUSH_CYCLES) ? LOAD_USE_STALL : FLUSH_CYCLES;
  localparam int unsigned RW   = $clog2(MAXC + 1);
  localparam logic [RW-1:0] STALL_RELOAD = RW'(LOAD_USE_STALL - 1);
  localparam logic [RW-1:0] FLUSH_RELOAD = RW'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0] ONE          = RW'(1);

  logic [1:0]    state, state_n;
  logic [1:0]    resume, resume_n;
  logic [1:0]    eff;
  logic [RW-1:0] rem, rem_n;
  logic          pend_valid, pend_valid_n;
  logic [31:0]   pend_addr, pend_addr_n;
  logic          hazard;

  assign hazard = (ex_opcode == 7'b0000011) && ex_rd_en && (ex_rd_addr != '0) &&
                  ((id_rs1_rd && (id_rs1_addr == ex_rd_addr)) ||
                   (id_rs2_rd && (id_rs2_addr == ex_rd_addr)));

  // FREEZE remembers which state it interrupted (and its remaining count) so
  // a pending bubble or flush sequence continues once memory is ready.
  assign eff = (state == FREEZE) ? resume : state;

  always_comb begin
    pc_stall          = 1'b0;
    if_id_stall       = 1'b0;
    load_hazerd       = 1'b0;
    flush_flag        = 1'b0;
    pipe_freeze       = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect_addr  = '0;
    state_n           = state;
    resume_n          = resume;
    rem_n             = rem;
    pend_valid_n      = pend_valid;
    pend_addr_n       = pend_addr;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        pipe_freeze = 1'b1;
        state_n     = FREEZE;
        if (state != FREEZE) resume_n = state;
        if (ex_redirect && !pend_valid) begin
          pend_valid_n = 1'b1;
          pend_addr_n  = ex_redirect_pc;
        end
      end else if (pend_valid || ex_redirect) begin
        flush_flag        = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect_addr  = pend_valid ? pend_addr : ex_redirect_pc;
        pend_valid_n      = 1'b0;
        if (FLUSH_CYCLES > 1) begin
          state_n = FLUSH;
          rem_n   = FLUSH_RELOAD;
        end else begin
          state_n = RUN;
        end
      end else if (eff == FLUSH) begin
        flush_flag = 1'b1;
        rem_n      = rem - ONE;
        state_n    = (rem == ONE) ? RUN : FLUSH;
      end else if (eff == LSTALL) begin
        load_hazerd = 1'b1;
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        rem_n       = rem - ONE;
        state_n     = (rem == ONE) ? RUN : LSTALL;
      end else if (hazard) begin
        load_hazerd = 1'b1;
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        if (LOAD_USE_STALL > 1) begin
          state_n = LSTALL;
          rem_n   = STALL_RELOAD;
        end else begin
          state_n = RUN;
        end
      end else begin
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      resume     <= RUN;
      rem        <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      state      <= state_n;
      resume     <= resume_n;
      rem        <= rem_n;
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(load_hazerd);
      flush_cnt <= flush_cnt + CNT_WIDTH'(pc_redirect_valid);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

  localparam int unsigned XRA = 5;
  localparam int unsigned L   = 3;
  localparam int unsigned F   = 2;
  localparam int unsigned CW  = 16;

  typedef struct packed {
    logic          pc_stall;
    logic          if_id_stall;
    logic          load_hazerd;
    logic          flush_flag;
    logic          pipe_freeze;
    logic          pc_redirect_valid;
    logic [31:0]   pc_redirect_addr;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
  } outs_t;

  logic clk = 1'b0;
  logic rst;
  logic [XRA-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_rs1_rd, id_rs2_rd, ex_rd_en, ex_redirect, mem_busy;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_redirect_pc;
  logic pc_stall, if_id_stall, load_hazerd, flush_flag, pipe_freeze, pc_redirect_valid;
  logic [31:0]   pc_redirect_addr;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .XREG_ADDRWIDTH(XRA),
    .LOAD_USE_STALL(L),
    .FLUSH_CYCLES(F),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs1_rd(id_rs1_rd),
    .id_rs2_addr(id_rs2_addr), .id_rs2_rd(id_rs2_rd),
    .ex_opcode(ex_opcode), .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .load_hazerd(load_hazerd),
    .flush_flag(flush_flag), .pipe_freeze(pipe_freeze),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_addr(pc_redirect_addr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  outs_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: remaining bubble/flush cycles and one pending redirect.
  int            bubbles_left = 0;
  int            flushes_left = 0;
  bit            pend = 1'b0;
  logic [31:0]   pend_pc = '0;
  logic [CW-1:0] n_stall = '0;
  logic [CW-1:0] n_flush = '0;

  task automatic step();
    outs_t e;
    bit    haz;
    e = '0;
    if (rst) begin
      bubbles_left = 0;
      flushes_left = 0;
      pend         = 1'b0;
      pend_pc      = '0;
      n_stall      = '0;
      n_flush      = '0;
    end else begin
`ifdef PIPE_PERF_CNT_EN
      e.stall_cnt = n_stall;
      e.flush_cnt = n_flush;
`endif
      haz = (ex_opcode == 7'h03) && ex_rd_en && (ex_rd_addr != 0) &&
            ((id_rs1_rd && id_rs1_addr == ex_rd_addr) || (id_rs2_rd && id_rs2_addr == ex_rd_addr));
      if (mem_busy) begin
        e.pc_stall = 1; e.if_id_stall = 1; e.pipe_freeze = 1;
        if (ex_redirect && !pend) begin
          pend    = 1'b1;
          pend_pc = ex_redirect_pc;
        end
      end else if (pend || ex_redirect) begin
        e.flush_flag = 1; e.pc_redirect_valid = 1;
        e.pc_redirect_addr = pend ? pend_pc : ex_redirect_pc;
        pend         = 1'b0;
        flushes_left = F - 1;
        bubbles_left = 0;
      end else if (flushes_left > 0) begin
        e.flush_flag = 1;
        flushes_left--;
      end else if (bubbles_left > 0) begin
        e.load_hazerd = 1; e.pc_stall = 1; e.if_id_stall = 1;
        bubbles_left--;
      end else if (haz) begin
        e.load_hazerd = 1; e.pc_stall = 1; e.if_id_stall = 1;
        bubbles_left = L - 1;
      end
      if (e.load_hazerd) n_stall = n_stall + 1'b1;
      if (e.pc_redirect_valid) n_flush = n_flush + 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_rd = 0; id_rs2_rd = 0;
    ex_opcode = 7'h13; ex_rd_en = 0; ex_rd_addr = 0;
    ex_redirect = 0; ex_redirect_pc = '0; mem_busy = 0;
  endtask

  task automatic set_load(input logic [XRA-1:0] rd, input logic en, input logic [XRA-1:0] rs1);
    ex_opcode = 7'h03; ex_rd_en = en; ex_rd_addr = rd;
    id_rs1_addr = rs1; id_rs1_rd = 1; id_rs2_addr = 7; id_rs2_rd = 1;
  endtask

  always @(negedge clk) begin
    outs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_stall, if_id_stall, load_hazerd, flush_flag, pipe_freeze, pc_redirect_valid,
           pc_redirect_addr, stall_cnt, flush_cnt};
      checks++;
      if (a !== e)
        begin
          errors++;
          $display("FAIL outs @%0t: got stl=%b ifid=%b haz=%b fl=%b frz=%b rv=%b addr=%h sc=%0d fc=%0d want stl=%b ifid=%b haz=%b fl=%b frz=%b rv=%b addr=%h sc=%0d fc=%0d",
                   $time, a.pc_stall, a.if_id_stall, a.load_hazerd, a.flush_flag, a.pipe_freeze,
                   a.pc_redirect_valid, a.pc_redirect_addr, a.stall_cnt, a.flush_cnt,
                   e.pc_stall, e.if_id_stall, e.load_hazerd, e.flush_flag, e.pipe_freeze,
                   e.pc_redirect_valid, e.pc_redirect_addr, e.stall_cnt, e.flush_cnt);
        end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    step(); step();
    rst = 0;
    step();
    // lw x5 in EX, add x6,x5,x7 in ID; load leaves EX after the first bubble
    set_load(5, 1, 5); step();
    idle(); step(); step(); step();
    // rd = x0 and rd_en = 0 never stall
    set_load(0, 1, 0); step();
    set_load(9, 0, 9); step();
    idle(); step();
    // redirect to 0x100
    ex_redirect = 1; ex_redirect_pc = 32'h100; step();
    idle(); step(); step();
    // redirect held while memory busy for three cycles
    mem_busy = 1; ex_redirect = 1; ex_redirect_pc = 32'h200; step(); step(); step();
    mem_busy = 0; step();
    idle(); step(); step();
    // hazard and redirect in the same cycle
    set_load(4, 1, 4); ex_redirect = 1; ex_redirect_pc = 32'h300; step();
    idle(); step(); step();
    // reset pulsed in the second bubble cycle
    set_load(6, 1, 6); step();
    rst = 1; step();
    idle(); step(); step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      id_rs1_addr    = XRA'($urandom_range(0, 3));
      id_rs2_addr    = XRA'($urandom_range(0, 3));
      id_rs1_rd      = $urandom_range(0, 1) == 1;
      id_rs2_rd      = $urandom_range(0, 1) == 1;
      ex_opcode      = ($urandom_range(0, 1) == 1) ? 7'h03 : 7'($urandom_range(0, 127));
      ex_rd_en       = $urandom_range(0, 3) != 0;
      ex_rd_addr     = XRA'($urandom_range(0, 3));
      ex_redirect    = ($urandom_range(0, 99) < 10);
      ex_redirect_pc = $urandom & 32'hFFFF_FFFC;
      mem_busy       = ($urandom_range(0, 99) < 15);
      step();
    end
    idle();
    step(); step();
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
